// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: memory function/type codes,
// responder FSM state constants and byte-enable / type-legality helpers.
package dmem_responder_pkg;

    typedef enum logic {
        M_XRD = 1'b0,
        M_XWR = 1'b1
    } t_m;

    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_D  = 3'd4,
        MT_BU = 3'd5,
        MT_HU = 3'd6,
        MT_WU = 3'd7
    } t_mt;

    localparam logic [31:0] START_ADDR = 32'h0000_2000;

    typedef logic [0:0] t_dmem_st;
    localparam t_dmem_st DM_IDLE = 1'b0;
    localparam t_dmem_st DM_RESP = 1'b1;

    function automatic logic typ_legal(input t_mt typ);
        return typ inside {MT_B, MT_H, MT_W, MT_BU, MT_HU};
    endfunction

    // Lane must already be aligned for halfword/word accesses.
    function automatic logic [3:0] byte_en(input t_mt typ, input logic [1:0] lane);
        case (typ)
            MT_B, MT_BU: byte_en = 4'b0001 << lane;
            MT_H, MT_HU: byte_en = 4'b0011 << lane;
            default:     byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory request/response bundle; master is the core, slave the memory.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    t_m          req_fcn;
    t_mt         req_typ;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_fcn, req_typ, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_fcn, req_typ, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/dmem_responder_sram.sv
// Single-port DEPTH_WORDS x 32 SRAM with byte enables, synchronous write and read.
// Latency 1 (rdata valid the cycle after en); rdata holds while en is low.
module dmem_responder_sram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane store masking, load extension; optional faults via DMEM_ERR_EN.
// Latency: one response per request, valid the cycle after acceptance (loads and stores alike).
// Backpressure: a held response blocks new requests unless it is consumed in the same cycle.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = START_ADDR
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave dmem
);
    localparam int IDXW = $clog2(DEPTH_WORDS);

    t_dmem_st    state_q, state_d;
    t_mt         typ_q, typ_d, eff_typ;
    logic [1:0]  lane_q, lane_d, eff_lane;
    logic        load_q, load_d;
    logic        accept, consume, fault;
    logic [31:0] off, wdata, rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign consume        = (state_q == DM_RESP) && dmem.resp_ready;
    assign dmem.req_ready = (state_q == DM_IDLE) || consume;
    assign accept         = dmem.req_valid && dmem.req_ready;
    assign off            = dmem.req_addr - BASE_ADDR;

`ifdef DMEM_ERR_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
    logic err_q, err_d;

    assign eff_typ  = dmem.req_typ;
    assign eff_lane = dmem.req_addr[1:0];
    always_comb begin
        fault = !typ_legal(dmem.req_typ) || ({1'b0, off} >= SPAN);
        if (dmem.req_typ inside {MT_H, MT_HU} && eff_lane[0]) fault = 1'b1;
        if (dmem.req_typ == MT_W && eff_lane != 2'd0)          fault = 1'b1;
    end
`else
    logic unused_off_hi;
    assign unused_off_hi = ^off[31:IDXW+2];
    assign fault         = 1'b0;
    // No fault reporting: illegal types behave as words, misaligned lanes snap down.
    always_comb begin
        eff_typ  = typ_legal(dmem.req_typ) ? dmem.req_typ : MT_W;
        eff_lane = dmem.req_addr[1:0];
        if (eff_typ inside {MT_H, MT_HU}) eff_lane[0] = 1'b0;
        if (eff_typ == MT_W)              eff_lane    = 2'd0;
    end
`endif

    always_comb begin
        case (eff_typ)
            MT_B, MT_BU: wdata = {4{dmem.req_data[7:0]}};
            MT_H, MT_HU: wdata = {2{dmem.req_data[15:0]}};
            default:     wdata = dmem.req_data;
        endcase
    end

    dmem_responder_sram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (IDXW)
    ) u_sram (
        .clk    (clk),
        .en_i   (accept),
        .we_i   (accept && (dmem.req_fcn == M_XWR) && !fault),
        .be_i   (byte_en(eff_typ, eff_lane)),
        .addr_i (off[IDXW+1:2]),
        .wdata_i(wdata),
        .rdata_o(rdata)
    );

    always_comb begin
        state_d = state_q;
        typ_d   = typ_q;
        lane_d  = lane_q;
        load_d  = load_q;
        if (accept) begin
            state_d = DM_RESP;
            typ_d   = eff_typ;
            lane_d  = eff_lane;
            load_d  = (dmem.req_fcn == M_XRD);
        end else if (consume) begin
            state_d = DM_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DM_IDLE;
            typ_q   <= MT_W;
            lane_q  <= 2'd0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            typ_q   <= typ_d;
            lane_q  <= lane_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = lane_q[1] ? rdata[31:16] : rdata[15:0];
        case (typ_q)
            MT_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            MT_BU:   ld_ext = {24'h0, ld_byte};
            MT_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            MT_HU:   ld_ext = {16'h0, ld_half};
            default: ld_ext = rdata;
        endcase
    end

    assign dmem.resp_valid = (state_q == DM_RESP);

`ifdef DMEM_ERR_EN
    assign err_d = accept ? fault : err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign dmem.resp_err  = dmem.resp_valid && err_q;
    assign dmem.resp_data = (dmem.resp_valid && load_q && !err_q) ? ld_ext : 32'h0;
`else
    assign dmem.resp_err  = 1'b0;
    assign dmem.resp_data = (dmem.resp_valid && load_q) ? ld_ext : 32'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, stall/reset sequences, random ops vs a byte-level model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .dmem (bus)
    );

    typedef struct {
        string       nm;
        logic [31:0] addr;
        t_m          fcn;
        t_mt         typ;
        logic [31:0] wdat;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    bit [7:0] mem_m [int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: memory as a flat byte map, access rules applied with plain arithmetic.
    task automatic model(input logic [31:0] a, input t_m f, input t_mt t, input logic [31:0] d,
                         output logic [31:0] rd, output logic re);
        int          size;
        bit          legal, sgn;
        logic [31:0] off, v;
        int          b;
        legal = (t == MT_B) || (t == MT_H) || (t == MT_W) || (t == MT_BU) || (t == MT_HU);
        size  = (t == MT_B || t == MT_BU) ? 1 : (t == MT_H || t == MT_HU) ? 2 : 4;
        sgn   = (t == MT_B || t == MT_H);
        off   = a - BASE;
        rd    = 32'h0;
        re    = 1'b0;
        if (ERR_EN && (!legal || (off % size) != 0 || off >= 4 * DEPTH)) begin
            re = 1'b1;
            return;
        end
        b = int'((off - (off % size)) % (4 * DEPTH));
        if (f == M_XWR) begin
            for (int i = 0; i < size; i++) mem_m[b + i] = d[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_m[b + i]) << (8 * i));
            if (sgn && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            rd = v;
        end
    endtask

    // One complete transaction; stall>0 holds resp_ready low and checks the response stays put.
    task automatic xact(input logic [31:0] a, input t_m f, input t_mt t, input logic [31:0] d,
                        input int stall, output logic [31:0] rd, output logic re);
        int n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.req_fcn    = f;
        bus.req_typ    = t;
        bus.req_data   = d;
        bus.resp_ready = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd = 32'h0;
        re = 1'b0;
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'(bus.req_ready), 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("latency_valid", 32'(bus.resp_valid), 32'h1);
        rd = bus.resp_data;
        re = bus.resp_err;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk("stall_hold", {bus.resp_data[30:0], bus.resp_err}, {rd[30:0], re});
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, md;
        logic        re, me;
        t_mt         rt;
        t_m          rf;
        logic [31:0] ra;

        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_fcn    = M_XRD;
        bus.req_typ    = MT_W;
        bus.req_data   = 32'h0;
        bus.resp_ready = 1'b0;

        // Reset state, during and right after reset
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_req_ready",  32'(bus.req_ready),  32'h1);
        chk("rst_resp_err",   32'(bus.resp_err),   32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("post_rst_req_ready",  32'(bus.req_ready),  32'h1);
        chk("post_rst_resp_data",  bus.resp_data,       32'h0);

        vecs.push_back('{"sw_8899aabb", 32'h2000, M_XWR, MT_W,  32'h8899AABB, 32'h0, 1'b0});
        vecs.push_back('{"lb_2003",     32'h2003, M_XRD, MT_B,  32'h0, 32'hFFFFFF88, 1'b0});
        vecs.push_back('{"lbu_2000",    32'h2000, M_XRD, MT_BU, 32'h0, 32'h000000BB, 1'b0});
        vecs.push_back('{"lh_2002",     32'h2002, M_XRD, MT_H,  32'h0, 32'hFFFF8899, 1'b0});
        vecs.push_back('{"lhu_2000",    32'h2000, M_XRD, MT_HU, 32'h0, 32'h0000AABB, 1'b0});
        vecs.push_back('{"lb_2001",     32'h2001, M_XRD, MT_B,  32'h0, 32'hFFFFFFAA, 1'b0});
        vecs.push_back('{"lhu_2002",    32'h2002, M_XRD, MT_HU, 32'h0, 32'h00008899, 1'b0});
        vecs.push_back('{"lw_2000",     32'h2000, M_XRD, MT_W,  32'h0, 32'h8899AABB, 1'b0});
        vecs.push_back('{"sw_zero",     32'h2004, M_XWR, MT_W,  32'h0, 32'h0, 1'b0});
        vecs.push_back('{"sb_2005",     32'h2005, M_XWR, MT_B,  32'h1234565A, 32'h0, 1'b0});
        vecs.push_back('{"lw_after_sb", 32'h2004, M_XRD, MT_W,  32'h0, 32'h00005A00, 1'b0});
        vecs.push_back('{"sh_2006",     32'h2006, M_XWR, MT_H,  32'hFFFFBEEF, 32'h0, 1'b0});
        vecs.push_back('{"lw_after_sh", 32'h2004, M_XRD, MT_W,  32'h0, 32'hBEEF5A00, 1'b0});
        vecs.push_back('{"lw_misalign", 32'h2002, M_XRD, MT_W,  32'h0,
                         ERR_EN ? 32'h0 : 32'h8899AABB, ERR_EN});
        vecs.push_back('{"ld_illegal",  32'h2000, M_XRD, MT_D,  32'h0,
                         ERR_EN ? 32'h0 : 32'h8899AABB, ERR_EN});
        vecs.push_back('{"sw_top",      32'h5FFC, M_XWR, MT_W,  32'h11111111, 32'h0, 1'b0});
        vecs.push_back('{"sw_below",    32'h1FFC, M_XWR, MT_W,  32'h22222222, 32'h0, ERR_EN});
        vecs.push_back('{"lw_top",      32'h5FFC, M_XRD, MT_W,  32'h0,
                         ERR_EN ? 32'h11111111 : 32'h22222222, 1'b0});

        foreach (vecs[i]) begin
            xact(vecs[i].addr, vecs[i].fcn, vecs[i].typ, vecs[i].wdat, i % 3, rd, re);
            chk({vecs[i].nm, "_data"}, rd, vecs[i].exp_dat);
            chk({vecs[i].nm, "_err"}, 32'(re), 32'(vecs[i].exp_err));
        end

        // Held response blocks a waiting request, then consume + accept share one edge
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h2000;
        bus.req_fcn   = M_XRD;
        bus.req_typ   = MT_W;
        @(posedge clk);
        #1;
        bus.req_addr = 32'h2006;
        bus.req_typ  = MT_HU;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.resp_valid), 32'h1);
            chk("stall_data",  bus.resp_data,       32'h8899AABB);
            chk("stall_ready", 32'(bus.req_ready),  32'h0);
        end
        bus.resp_ready = 1'b1;
        #1;
        chk("consume_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(bus.resp_valid), 32'h1);
        chk("b2b_data",  bus.resp_data,       32'h0000BEEF);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;

        // Reset while a store response is pending; the store itself must survive
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h2008;
        bus.req_fcn   = M_XWR;
        bus.req_typ   = MT_W;
        bus.req_data  = 32'h1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.resp_valid), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.resp_valid), 32'h0);
        chk("mid_rst_ready", 32'(bus.req_ready),  32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        xact(32'h2008, M_XRD, MT_W, 32'h0, 0, rd, re);
        chk("lw_after_rst", rd, 32'h1);

        // Random traffic within a 16-word window, seeded with known words first
        for (int w = 0; w < 16; w++) begin
            md = $urandom;
            model(BASE + 32'(4 * w), M_XWR, MT_W, md, rd, me);
            xact(BASE + 32'(4 * w), M_XWR, MT_W, md, 0, rd, re);
        end
        for (int k = 0; k < 300; k++) begin
            ra = BASE + 32'($urandom_range(0, 63));
            rf = ($urandom_range(0, 2) == 0) ? M_XWR : M_XRD;
            rt = t_mt'(3'($urandom_range(0, 7)));
            md = $urandom;
            model(ra, rf, rt, md, rd, me);
            xact(ra, rf, rt, md, int'($urandom_range(0, 2)), md, re);
            chk("rand_data", md, rd);
            chk("rand_err",  32'(re), 32'(me));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
